pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 36 +++
 rtl/pipeline_hazard_ctrl_if.sv | 50 +++++
 rtl/pipeline_hazard_ctrl_sat_counter32.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// otter_pipe_pkg
// Shared types and constants for the pipeline hazard controller.
//   hz_state_e  : controller FSM states (RUN, MEM_WAIT)
//   pcsource_e  : execute-stage PC select encodings
//   REG_X0      : hard-wired zero register, never a hazard source
//   src_hazard  : helper that tests one decode source against a load target
// ---------------------------------------------------------------------------
package otter_pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        JALR     = 2'd1,
        BRANCH   = 2'd2,
        JAL      = 2'd3
    } pcsource_e;

    localparam int REG_W   = 5;
    localparam int TIMER_W = 8;

    localparam logic [REG_W-1:0] REG_X0 = 5'd0;

    // A source only conflicts when it is actually read and the load target
    // is a real register; x0 writes are discarded so they can never hazard.
    function automatic logic src_hazard(input logic             uses,
                                        input logic [REG_W-1:0] rs,
                                        input logic [REG_W-1:0] rd);
        return uses && (rs == rd) && (rd != REG_X0);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   master modport : datapath side, drives hazard inputs, receives enables
//   slave modport  : controller side
// Signals:
//   id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 : decode-stage sources
//   ex_rd, ex_memread2                     : ID/EX destination and load flag
//   pcsource                               : execute-stage PC select
//   mem_req, mem_ack                       : data memory handshake
//   pc_write, if_id_write, id_ex_write, ex_ms_write : stage load enables
//   if_id_flush, id_ex_flush               : bubble insertion
//   mem_err                                : sticky memory timeout flag
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
    import otter_pipe_pkg::*;

    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_memread2;
    logic [1:0]       pcsource;
    logic             mem_req;
    logic             mem_ack;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             ex_ms_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_err;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memread2,
               pcsource, mem_req, mem_ack,
        input  pc_write, if_id_write, id_ex_write, ex_ms_write,
               if_id_flush, id_ex_flush, mem_err
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memread2,
               pcsource, mem_req, mem_ack,
        output pc_write, if_id_write, id_ex_write, ex_ms_write,
               if_id_flush, id_ex_flush, mem_err
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter32.sv
// ---------------------------------------------------------------------------
// sat_counter32
// 32-bit up counter with enable that sticks at all-ones.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count this cycle
//   count      : current value
// ---------------------------------------------------------------------------
module sat_counter32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush controller for a 5-stage pipeline. Priority is
// memory freeze > redirect > load-use stall > normal advance.
// Parameter:
//   MEM_TIMEOUT : freeze cycles without mem_ack before abort (1..255)
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   hz          : pipeline_hazard_ctrl_if.slave (hazard inputs, enables,
//                 flushes, sticky mem_err)
//   stall_cnt   : cycles with pc_write low (only with HAZARD_PERF_EN)
//   flush_cnt   : redirect cycles           (only with HAZARD_PERF_EN)
// Configuration macro: HAZARD_PERF_EN adds the two saturating counters.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import otter_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    hz_state_e          state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               mem_err_q, mem_err_d;
    logic               frozen;
    logic               redirect;
    logic               load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            timer_q   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            mem_err_q <= mem_err_d;
        end
    end

    // In MEM_WAIT the request is already outstanding, so only the ack matters.
    // Outputs are forced to zero while reset is held so no stage loads.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        mem_err_d = mem_err_q;

        frozen   = (state_q == RUN) ? (hz.mem_req && !hz.mem_ack) : !hz.mem_ack;
        redirect = (hz.pcsource != PC_PLUS4);
        load_use = hz.ex_memread2 &&
                   (src_hazard(hz.id_uses_rs1, hz.id_rs1, hz.ex_rd) ||
                    src_hazard(hz.id_uses_rs2, hz.id_rs2, hz.ex_rd));

        hz.pc_write    = 1'b1;
        hz.if_id_write = 1'b1;
        hz.id_ex_write = 1'b1;
        hz.ex_ms_write = 1'b1;
        hz.if_id_flush = 1'b0;
        hz.id_ex_flush = 1'b0;

        case (state_q)
            RUN: begin
                if (hz.mem_req && !hz.mem_ack) begin
                    state_d = MEM_WAIT;
                    timer_d = TIMER_W'(1);
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ack) begin
                    state_d = RUN;
                    timer_d = '0;
                end else if (timer_q == TIMER_W'(MEM_TIMEOUT)) begin
                    state_d   = RUN;
                    timer_d   = '0;
                    mem_err_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                timer_d = '0;
            end
        endcase

        if (!rst_n || frozen) begin
            hz.pc_write    = 1'b0;
            hz.if_id_write = 1'b0;
            hz.id_ex_write = 1'b0;
            hz.ex_ms_write = 1'b0;
        end else if (redirect) begin
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else if (load_use) begin
            hz.pc_write    = 1'b0;
            hz.if_id_write = 1'b0;
            hz.id_ex_flush = 1'b1;
        end
    end

    assign hz.mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
    // A redirect cycle is exactly the one where the IF/ID flush fires.
    sat_counter32 u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!hz.pc_write),
        .count (stall_cnt)
    );

    sat_counter32 u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (hz.if_id_flush),
        .count (flush_cnt)
    );
`endif

endmodule
